ifu_fetch: RTL

- Multicycle instruction fetch unit, directly upstream of the decode stage.
- Holds the architectural PC and issues one AXI4-Lite read per instruction.
- Presents {inst, pc, fault} to decode over a valid/ready handshake.
- Waits for the next PC from the execute/writeback path before fetching again.
- Exactly one instruction is in flight at any time.

---
 rtl/ifu_fetch.sv | 93 +++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Multicycle instruction fetch: one AXI4-Lite read per instruction, result handed
// to decode over valid/ready, then waits for the next PC from execute/writeback.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic [31:0] fetch_cnt
);

    localparam logic [1:0] S_AR  = 2'd0;
    localparam logic [1:0] S_R   = 2'd1;
    localparam logic [1:0] S_OUT = 2'd2;
    localparam logic [1:0] S_NPC = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] inst_reg;
    logic        fault_reg;

    // Gating with rst keeps the handshakes low while reset is asserted.
    assign arvalid   = (state == S_AR) && rst;
    assign rready    = (state == S_R) && rst;
    assign out_valid = (state == S_OUT) && rst;
    assign araddr    = pc;
    assign out_inst  = inst_reg;
    assign out_pc    = pc;
    assign out_fault = fault_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_AR;
            pc        <= RESET_PC;
            inst_reg  <= '0;
            fault_reg <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                S_AR: begin
                    if (arready) state <= S_R;
                end
                S_R: begin
                    if (rvalid) begin
                        state <= S_OUT;
                        if (rresp == 2'b00) begin
                            inst_reg  <= rdata;
                            fault_reg <= 1'b0;
                        end else begin
                            inst_reg  <= NOP_INST;
                            fault_reg <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state     <= S_NPC;
                        fetch_cnt <= fetch_cnt + 32'd1;
                    end
                end
                S_NPC: begin
                    if (npc_valid) begin
                        pc <= npc;
                        // A misaligned target never reaches the bus; it is reported as a faulting NOP.
                        if (npc[1:0] == 2'b00) begin
                            state <= S_AR;
                        end else begin
                            inst_reg  <= NOP_INST;
                            fault_reg <= 1'b1;
                            state     <= S_OUT;
                        end
                    end
                end
                default: state <= S_AR;
            endcase
        end
    end

endmodule
